// File: rtl/regfile_2w_bypass_sb.sv
// ---------------------------------------------------------------------------
// regfile_2w_bypass_sb
//   General-purpose register file for the decode stage of the pipelined core.
//   Two combinational read ports and two synchronous write ports. Optional
//   write-to-read bypass, optional hardwired-zero register 0, and a
//   per-register scoreboard of pending writes so decode can detect RAW
//   hazards.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    register address width (DEPTH = 2**ADDR_W)
//   ZERO_REG  1: register 0 reads 0, is never busy, writes/sets are discarded
//   BYPASS    1: same-cycle write data forwarded to matching read ports
//
// Ports
//   clk                     clock, all state changes on the rising edge
//   reset                   synchronous active-high reset
//   rd_addr_a / rd_addr_b   read addresses
//   rd_data_a / rd_data_b   read data (combinational)
//   busy_a / busy_b         pending-write flag for the addressed register
//   wr_en0/addr0/data0      write port 0 (MEM writeback)
//   wr_en1/addr1/data1      write port 1 (ALU writeback, higher priority)
//   sb_set / sb_addr        mark sb_addr as having a pending write (issue)
// ---------------------------------------------------------------------------
module regfile_2w_bypass_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_sb;

  logic              w_we0;
  logic              w_we1;
  logic              w_set;
  logic              w_same_addr;
  logic [DEPTH-1:0]  w_sb_next;

  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [DATA_W-1:0] w_rd_data [2];
  logic              w_busy    [2];
  logic              w_hit0    [2];
  logic              w_hit1    [2];

  // Address 0 is the hardwired-zero register only when ZERO_REG is enabled.
  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Effective enables: anything aimed at a hardwired-zero register 0 is dropped.
  always_comb begin
    w_we0       = wr_en0 && !is_zero_addr(wr_addr0);
    w_we1       = wr_en1 && !is_zero_addr(wr_addr1);
    w_set       = sb_set && !is_zero_addr(sb_addr);
    w_same_addr = w_we1 && (wr_addr1 == wr_addr0);
  end

  // Scoreboard next state: writebacks clear, issue sets. The set is applied
  // last so a reissued destination stays pending.
  always_comb begin
    // NOTE: give every always_comb output a default before any conditional
    // assignment, otherwise a path that skips it infers a latch.
    w_sb_next = r_sb;
    if (w_we0) w_sb_next[wr_addr0] = 1'b0;
    if (w_we1) w_sb_next[wr_addr1] = 1'b0;
    if (w_set) w_sb_next[sb_addr]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register array is cleared on reset because software relies
      // on every register reading zero afterwards; this forces flops rather
      // than a RAM macro, which is acceptable at this depth.
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_sb <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (w_we0 && !w_same_addr) r_regs[wr_addr0] <= wr_data0;
      if (w_we1)                 r_regs[wr_addr1] <= wr_data1;
      r_sb <= w_sb_next;
    end
  end

  assign w_rd_addr[0] = rd_addr_a;
  assign w_rd_addr[1] = rd_addr_b;

  // Read ports. Bypass is suppressed during reset (the writes are ignored
  // that cycle) and for a hardwired-zero register 0.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_hit1[p] = (BYPASS != 0) && !reset && wr_en1 &&
                  (wr_addr1 == w_rd_addr[p]) && !is_zero_addr(w_rd_addr[p]);
      w_hit0[p] = (BYPASS != 0) && !reset && wr_en0 &&
                  (wr_addr0 == w_rd_addr[p]) && !is_zero_addr(w_rd_addr[p]);

      if (is_zero_addr(w_rd_addr[p])) begin
        w_rd_data[p] = '0;
        w_busy[p]    = 1'b0;
      end else begin
        if (w_hit1[p])      w_rd_data[p] = wr_data1;
        else if (w_hit0[p]) w_rd_data[p] = wr_data0;
        else                w_rd_data[p] = r_regs[w_rd_addr[p]];
        // A register being written back this cycle is no longer a hazard
        // once its data is forwarded.
        w_busy[p] = r_sb[w_rd_addr[p]] && !(w_hit1[p] || w_hit0[p]);
      end
    end
  end

  assign rd_data_a = w_rd_data[0];
  assign rd_data_b = w_rd_data[1];
  assign busy_a    = w_busy[0];
  assign busy_b    = w_busy[1];

endmodule
